// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizes for the truth-table sweeper and its settle timer.
package truth_table_sweeper_pkg;

    localparam int unsigned N_VEC = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Load/enable counter that flags the last cycle of a vector's settle interval.
module settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Count holds the number of settle cycles already spent, so the last one is SETTLE_CYCLES-1.
    assign expired_c = (count == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input sweeper: drives all vectors, captures f, compares against a golden table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_VEC-1:0]  expected,
    input  logic              f_in,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              busy,
    output logic              done,
    output logic [N_VEC-1:0]  table_out,
    output logic [ERR_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic              mismatch
);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [N_VEC-1:0]   exp_q;
    logic               accept;
    logic               sample;
    logic               advance;
    logic               tmr_load;
    logic               tmr_en;
    logic               expired_c;
    logic               hit_c;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .en        (tmr_en),
        .expired_c (expired_c)
    );

    assign hit_c = f_in ^ exp_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample     = 1'b0;
        advance    = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept     = 1'b1;
                    tmr_load   = 1'b1;
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (expired_c) begin
                        next_state = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    sample = 1'b1;
                    if (idx == IDX_W'(N_VEC - 1)) begin
                        next_state = FINISH;
                    end else begin
                        advance    = 1'b1;
                        tmr_load   = 1'b1;
                        next_state = SETTLE;
                    end
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Vector drive, capture and compare registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            exp_q         <= '0;
            {a, b, c, d}  <= 4'h0;
            busy          <= 1'b0;
            done          <= 1'b0;
            table_out     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            mismatch      <= 1'b0;
        end else begin
            busy <= (next_state == SETTLE) || (next_state == SAMPLE);
            done <= (state == FINISH);
            if (accept) begin
                idx           <= '0;
                exp_q         <= expected;
                {a, b, c, d}  <= 4'h0;
                table_out     <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
                mismatch      <= 1'b0;
            end
            if (sample) begin
                table_out[idx] <= f_in;
                if (hit_c) begin
                    err_count <= err_count + ERR_W'(1);
                    mismatch  <= 1'b1;
                    if (err_count == '0) begin
                        first_err_idx <= idx;
                    end
                end
            end
            if (advance) begin
                idx          <= idx + IDX_W'(1);
                {a, b, c, d} <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed scoreboard bench for truth_table_sweeper (SETTLE_CYCLES 2 and 1 instances).
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [15:0] expected = 16'h0;
    logic        f_in, f_in2;
    logic        a, b, c, d, busy, done, mismatch;
    logic        a2, b2, c2, d2, busy2, done2, mismatch2;
    logic [15:0] table_out, table_out2;
    logic [4:0]  err_count, err_count2;
    logic [3:0]  first_err_idx, first_err_idx2;

    logic [15:0] f_src = 16'h0;
    int          fmode = 0;
    int          cyc = 0, k = 0, k2 = 0, done_cnt = 0;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  err;
        logic [3:0]  first;
        logic        mism;
    } res_t;
    res_t sb[$];

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .f_in(f_in), .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
        .table_out(table_out), .err_count(err_count),
        .first_err_idx(first_err_idx), .mismatch(mismatch)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .expected(expected),
        .f_in(f_in2), .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
        .table_out(table_out2), .err_count(err_count2),
        .first_err_idx(first_err_idx2), .mismatch(mismatch2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // Function under test: mode 0 good, 1 inverts vector 6, 2 stuck at 0.
    function automatic logic model_f(input logic [15:0] src, input int mode, input logic [3:0] v);
        logic r;
        r = src[v];
        if (mode == 1 && v == 4'd6) r = ~r;
        if (mode == 2) r = 1'b0;
        return r;
    endfunction

    assign f_in  = model_f(f_src, fmode, {a, b, c, d});
    assign f_in2 = model_f(f_src, 0, {a2, b2, c2, d2});

    function automatic res_t predict(input logic [15:0] e, input int mode);
        res_t r;
        logic [3:0] v;
        r.tbl = 16'h0; r.err = 5'd0; r.first = 4'd0; r.mism = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            r.tbl[i] = model_f(e, mode, v);
            if (r.tbl[i] != e[i]) begin
                if (r.err == 5'd0) r.first = v;
                r.err = r.err + 5'd1;
                r.mism = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [15:0] e, input int mode, input bit push);
        @(negedge clk);
        expected = e;
        f_src    = e;
        fmode    = mode;
        start    = 1'b1;
        k        = cyc + 1;
        if (push) sb.push_back(predict(e, mode));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string tag, input int lat);
        res_t r;
        int   n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_cycle"}, cyc, k + lat);
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({tag, "_table"}, table_out, r.tbl);
            chk({tag, "_err"}, err_count, r.err);
            chk({tag, "_first"}, first_err_idx, r.first);
            chk({tag, "_mismatch"}, mismatch, r.mism);
        end
        chk({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_vec_hold"}, {a, b, c, d}, 4'hF);
    endtask

    initial begin
        int d0;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_vec", {a, b, c, d}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_table", table_out, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_idx, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_busy2", busy2, 0);
        rst = 1'b0;

        kick(16'hA5A5, 0, 1'b1);
        wait_done("golden", 49);

        kick(16'h00F0, 1, 1'b1);
        wait_done("fault6", 49);
        chk("fault6_table_const", table_out, 16'h00B0);

        kick(16'hFFFF, 2, 1'b1);
        wait_done("stuck0", 49);
        chk("stuck0_err_const", err_count, 16);

        // Abort while sampling vector 6: only vectors 0..5 captured
        kick(16'hA5A5, 0, 1'b0);
        while (cyc < k + 20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        d0 = done_cnt;
        chk("abort_busy", busy, 0);
        chk("abort_vec", {a, b, c, d}, 4'h6);
        chk("abort_table", table_out, 16'h0025);
        chk("abort_err", err_count, 0);
        repeat (60) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_vec_hold", {a, b, c, d}, 4'h6);

        // start together with abort in IDLE is ignored
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("startabort_busy", busy, 0);
        @(negedge clk);
        chk("startabort_busy2", busy, 0);
        chk("startabort_table", table_out, 16'h0025);

        // Mid-sweep start pulses and expected changes are ignored
        kick(16'hA5A5, 0, 1'b1);
        while (cyc < k + 10) @(negedge clk);
        start = 1'b1;
        expected = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 30) @(negedge clk);
        start = 1'b1;
        expected = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored", 49);

        // Reset mid-sweep
        kick(16'h00F0, 1, 1'b0);
        while (cyc < k + 30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_vec", {a, b, c, d}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_table", table_out, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_first", first_err_idx, 0);
        chk("midrst_mismatch", mismatch, 0);
        rst = 1'b0;

        // Short settle instance
        @(negedge clk);
        expected = 16'hA5A5;
        f_src    = 16'hA5A5;
        start2   = 1'b1;
        k2       = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        chk("s1_busy", busy2, 1);
        for (int n = 0; n < 200 && !done2; n++) @(negedge clk);
        chk("s1_done_cycle", cyc, k2 + 33);
        chk("s1_table", table_out2, 16'hA5A5);
        chk("s1_err", err_count2, 0);
        chk("s1_mismatch", mismatch2, 0);
        chk("s1_vec", {a2, b2, c2, d2}, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
